// File: rtl/rule_scan_seq_pkg.sv
// Shared types and helpers for the rule-slot scan sequencer.
package rule_scan_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int IDX_W     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Result of a slot search: found flag plus the slot index.
    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } next_t;

    // Decoder select is wired LSB-first: sel_w[2] carries idx[0].
    function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] i);
        return {i[0], i[1], i[2]};
    endfunction

    // Lowest set mask bit strictly above idx.
    function automatic next_t next_set(input logic [NUM_SLOTS-1:0] m,
                                       input logic [IDX_W-1:0]     idx);
        next_t r;
        r = '0;
        // Descending walk so the lowest qualifying bit is the last one written.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (i > int'(idx) && m[i]) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

    // Lowest set mask bit overall; found is clear only for an empty mask.
    function automatic next_t first_set(input logic [NUM_SLOTS-1:0] m);
        next_t r;
        if (m[0]) r = '{found: 1'b1, idx: '0};
        else      r = next_set(m, '0);
        return r;
    endfunction

endpackage

// File: rtl/rule_scan_seq_if.sv
// Handshake and decoder-drive bundle between a scan requester and the sequencer.
interface rule_scan_seq_if;
    import rule_scan_pkg::*;

    logic                 start;
    logic                 abort;
    logic [NUM_SLOTS-1:0] mask;
    logic                 busy;
    logic                 done;
    logic [IDX_W-1:0]     sel_w;
    logic                 sel_en;
    logic [IDX_W-1:0]     cur_idx;

    modport master (
        output start, abort, mask,
        input  busy, done, sel_w, sel_en, cur_idx
    );

    modport slave (
        input  start, abort, mask,
        output busy, done, sel_w, sel_en, cur_idx
    );
endinterface

// File: rtl/rule_scan_seq_dwell_cnt.sv
// Dwell counter: counts held cycles of the current slot, flags the last one.
module dwell_cnt #(
    parameter int CNT_W = 4,
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [CNT_W-1:0] cnt;

    // Clear wins over count so a slot change restarts the dwell at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == CNT_W'(DWELL - 1));
endmodule

// File: rtl/rule_scan_seq.sv
// Rule-slot scan sequencer driving the 3-to-8 decoder select/enable.
// Optional macro SCAN_CONTINUOUS_EN: wrap from highest to lowest set slot
// (done pulses at each wrap) until aborted, instead of a single pass.
module rule_scan_seq
    import rule_scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    rule_scan_seq_if.slave   bus
);
    state_t               state;
    logic [NUM_SLOTS-1:0] mask_q;
    logic                 busy_q, done_q, sel_en_q;
    logic [IDX_W-1:0]     sel_w_q, cur_idx_q;
    logic                 tc, cnt_clr, cnt_en;
    next_t                first, nxt;
`ifdef SCAN_CONTINUOUS_EN
    next_t                wrap;
    assign wrap = first_set(mask_q);
`endif

    assign first = first_set(bus.mask);
    assign nxt   = next_set(mask_q, cur_idx_q);

    // Counter only runs while a slot is held; any slot change or exit clears it.
    assign cnt_en  = (state == SCAN);
    assign cnt_clr = (state != SCAN) | tc | bus.abort;

    dwell_cnt #(.CNT_W(CNT_W), .DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (tc)
    );

    // Scan FSM with registered decoder drive and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mask_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sel_en_q  <= 1'b0;
            sel_w_q   <= '0;
            cur_idx_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mask_q <= bus.mask;
                        busy_q <= 1'b1;
                        if (first.found) begin
                            state     <= SCAN;
                            sel_en_q  <= 1'b1;
                            cur_idx_q <= first.idx;
                            sel_w_q   <= bitrev3(first.idx);
                        end else begin
                            state  <= FIN;
                            done_q <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (bus.abort) begin
                        state    <= FIN;
                        sel_en_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (tc) begin
                        if (nxt.found) begin
                            cur_idx_q <= nxt.idx;
                            sel_w_q   <= bitrev3(nxt.idx);
                        end
`ifdef SCAN_CONTINUOUS_EN
                        else if (wrap.found) begin
                            cur_idx_q <= wrap.idx;
                            sel_w_q   <= bitrev3(wrap.idx);
                            done_q    <= 1'b1;
                        end
`endif
                        else begin
                            state    <= FIN;
                            sel_en_q <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy_q   <= 1'b0;
                    sel_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sel_en  = sel_en_q;
    assign bus.sel_w   = sel_w_q;
    assign bus.cur_idx = cur_idx_q;
endmodule

// File: tb/tb_rule_scan_seq.sv
// Directed bench for rule_scan_seq: one DUT with DWELL=4 (d=0), one with DWELL=2 (d=1).
module tb_rule_scan_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Hand-written decoder select per logical slot (LSB-first wiring).
    logic [2:0] swtab [8] = '{3'b000, 3'b100, 3'b010, 3'b110,
                              3'b001, 3'b101, 3'b011, 3'b111};

    rule_scan_seq_if b4 ();
    rule_scan_seq_if b2 ();

    rule_scan_seq #(.DWELL(4), .CNT_W(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    rule_scan_seq #(.DWELL(2), .CNT_W(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] obs(input int d);
        if (d == 0) return {b4.busy, b4.done, b4.sel_en, b4.sel_w, b4.cur_idx};
        else        return {b2.busy, b2.done, b2.sel_en, b2.sel_w, b2.cur_idx};
    endfunction

    task automatic chk(input string tag, input logic [8:0] o, input logic [8:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    // Full output check while a slot is held.
    task automatic chk_slot(input string tag, input int d, input logic b,
                            input logic dn, input logic [2:0] idx);
        chk(tag, obs(d), {b, dn, 1'b1, swtab[idx], idx});
    endtask

    // Control-only check (busy, done, sel_en) outside slot holding.
    task automatic chk_ctl(input string tag, input int d, input logic b,
                           input logic dn, input logic e);
        logic [8:0] o;
        o = obs(d);
        chk(tag, {o[8:6], 6'b0}, {b, dn, e, 6'b0});
    endtask

    task automatic set_in(input int d, input logic s, input logic a, input logic [7:0] m);
        if (d == 0) begin b4.start = s; b4.abort = a; b4.mask = m; end
        else        begin b2.start = s; b2.abort = a; b2.mask = m; end
    endtask

    task automatic set_abort(input int d, input logic a);
        if (d == 0) b4.abort = a; else b2.abort = a;
    endtask

    task automatic set_start(input int d, input logic s);
        if (d == 0) b4.start = s; else b2.start = s;
    endtask

    // Pulse start at cycle 0; returns positioned at cycle 1.
    task automatic go(input int d, input logic [7:0] m);
        set_in(d, 1'b1, 1'b0, m);
        tick();
        set_start(d, 1'b0);
    endtask

    // Cycle after the last slot: FIN in single-pass, wrap to lowest slot otherwise.
    task automatic end_pass(input string tag, input int d, input logic [2:0] low);
`ifdef SCAN_CONTINUOUS_EN
        chk_slot({tag, "_wrap"}, d, 1'b1, 1'b1, low);
        set_abort(d, 1'b1);
        tick();
        set_abort(d, 1'b0);
        chk_ctl({tag, "_fin"}, d, 1'b1, 1'b1, 1'b0);
`else
        chk_ctl({tag, "_fin"}, d, 1'b1, 1'b1, 1'b0);
        if (low > 3'd7) chk_ctl({tag, "_bad"}, d, 1'b0, 1'b0, 1'b0);
`endif
        tick();
        chk_ctl({tag, "_idle"}, d, 1'b0, 1'b0, 1'b0);
    endtask

    // mask=FF on the DWELL=4 DUT; mask changed and start pulsed mid-scan.
    task automatic run_full(input string tag);
        go(0, 8'hFF);
        for (int c = 1; c <= 32; c++) begin
            chk_slot(tag, 0, 1'b1, 1'b0, 3'((c - 1) / 4));
            if (c == 5)  b4.mask  = 8'h00;
            if (c == 10) b4.start = 1'b1;
            if (c == 11) b4.start = 1'b0;
            tick();
        end
        end_pass(tag, 0, 3'd0);
    endtask

    initial begin
        set_in(0, 1'b0, 1'b0, 8'h00);
        set_in(1, 1'b0, 1'b0, 8'h00);
        #12;
        chk("reset_u4", obs(0), 9'b0);
        chk("reset_u2", obs(1), 9'b0);
        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", obs(0), 9'b0);

        // Full scan, 8 slots of 4 cycles, done at cycle 33.
        run_full("full");
        tick();

        // Reset asserted at cycle 10 of a scan: outputs clear at once, no done.
        go(0, 8'hFF);
        for (int c = 1; c < 10; c++) tick();
        chk_slot("pre_rst", 0, 1'b1, 1'b0, 3'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst", obs(0), 9'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_hold", obs(0), 9'b0);
        end
        rst_n = 1'b1;
        tick();
        run_full("full2");
        tick();

        // Sparse mask on DWELL=2: slots 0,2,7, done at cycle 7.
        go(1, 8'b1000_0101);
        for (int c = 1; c <= 6; c++) begin
            chk_slot("sparse", 1, 1'b1, 1'b0, (c <= 2) ? 3'd0 : (c <= 4) ? 3'd2 : 3'd7);
            tick();
        end
        end_pass("sparse", 1, 3'd0);
        tick();

        // Empty mask: FIN at cycle 1, no sel_en ever.
        go(1, 8'h00);
        chk_ctl("empty_fin", 1, 1'b1, 1'b1, 1'b0);
        tick();
        chk_ctl("empty_idle", 1, 1'b0, 1'b0, 1'b0);
        tick();

        // Abort during slot 3 with an ignored start pulse while busy.
        go(0, 8'hFF);
        for (int c = 1; c <= 14; c++) begin
            chk_slot("abort_run", 0, 1'b1, 1'b0, 3'((c - 1) / 4));
            if (c == 5)  b4.start = 1'b1;
            if (c == 6)  b4.start = 1'b0;
            if (c == 14) b4.abort = 1'b1;
            tick();
        end
        b4.abort = 1'b0;
        chk_ctl("abort_fin", 0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_ctl("abort_idle", 0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_ctl("abort_noqueue", 0, 1'b0, 1'b0, 1'b0);

        // Abort on the dwell-expiry cycle wins over the slot step.
        go(0, 8'hFF);
        for (int c = 1; c <= 4; c++) begin
            chk_slot("abort_tc_run", 0, 1'b1, 1'b0, 3'd0);
            if (c == 4) b4.abort = 1'b1;
            tick();
        end
        b4.abort = 1'b0;
        chk("abort_tc_fin", obs(0), {3'b110, 3'b000, 3'd0});
        tick();
        chk_ctl("abort_tc_idle", 0, 1'b0, 1'b0, 1'b0);

        // Start together with abort in IDLE: start wins.
        set_in(1, 1'b1, 1'b1, 8'h01);
        tick();
        set_in(1, 1'b0, 1'b0, 8'h01);
        chk_slot("st_ab_c1", 1, 1'b1, 1'b0, 3'd0);
        tick();
        chk_slot("st_ab_c2", 1, 1'b1, 1'b0, 3'd0);
        tick();
        end_pass("st_ab", 1, 3'd0);
        tick();

        // mask=81 on DWELL=2: single pass 0,7 or continuous 0,7,0,7 with wrap dones.
        go(1, 8'h81);
`ifdef SCAN_CONTINUOUS_EN
        for (int c = 1; c <= 8; c++) begin
            chk_slot("cont", 1, 1'b1, (c == 5), (c <= 2 || c == 5 || c == 6) ? 3'd0 : 3'd7);
            tick();
        end
`else
        for (int c = 1; c <= 4; c++) begin
            chk_slot("m81", 1, 1'b1, 1'b0, (c <= 2) ? 3'd0 : 3'd7);
            tick();
        end
`endif
        end_pass("m81", 1, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
